// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and operand-sign helpers for the multiply/divide unit.
package muldiv_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
    localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
    localparam logic [OP_W-1:0] OP_REM    = 3'b110;
    localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_e;

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return op == OP_MULH || op == OP_DIV || op == OP_REM;
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
// Ports: in_valid/in_ready/in_op/in_a/in_b/in_tag request side, flush abort,
// out_valid/out_ready/out_result/out_tag response side, busy status.
interface muldiv_if #(parameter int XLEN = 32, parameter int TAG_W = 5);
    logic                          in_valid;
    logic                          in_ready;
    logic [muldiv_pkg::OP_W-1:0]   in_op;
    logic [XLEN-1:0]               in_a;
    logic [XLEN-1:0]               in_b;
    logic [TAG_W-1:0]              in_tag;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [XLEN-1:0]               out_result;
    logic [TAG_W-1:0]              out_tag;
    logic                          busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_divider.sv
// muldiv_divider: unsigned radix-2 restoring divider datapath (one quotient bit per step).
// Ports: clk, reset_n; start_i loads dividend_i/divisor_i and the step counter;
// step_i performs one shift/subtract; done_o high when the counter is 0;
// quot_o/rem_o are the unsigned quotient and remainder after the last step.
module muldiv_divider #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [XLEN:0]   shifted;
    logic            ge;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while the new quotient bit enters at the LSB.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign done_o  = cnt_q == '0;
    assign quot_o  = quo_q;
    assign rem_o   = rem_q;

    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (start_i) begin
            cnt_d = CW'(XLEN - 1);
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            // Partial remainder stays below the divisor, so the low XLEN bits suffice.
            rem_d = ge ? shifted[XLEN-1:0] - dvs_q : shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ge};
            cnt_d = done_o ? cnt_q : cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RISC-V M-extension multiply/divide unit with valid/ready handshakes and flush.
// Ports: clk, reset_n (async active-low); io (muldiv_if.slave) carrying the
// request handshake, flush, response handshake and busy status.
// Multiplies and divide special cases finish in one cycle; normal divides
// iterate XLEN steps in muldiv_divider followed by one sign-fixup cycle.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  io
);
    state_e           state_q, state_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rem_op_q, rem_op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             sa, sb;
    logic [XLEN:0]    ma, mb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  mul_res, mag_a, mag_b, spec_res, quot, rem;
    logic             b_zero, ovf, start, step, div_done;

    // Operand sign bits: set only when the op treats that operand as signed
    // and it is negative; they drive both the multiply extension and the
    // divide sign bookkeeping.
    assign sa = is_signed_a(io.in_op) & io.in_a[XLEN-1];
    assign sb = is_signed_b(io.in_op) & io.in_b[XLEN-1];

    // XLEN+1-bit signed operands, sign-extended to 2*XLEN so an unsigned
    // multiply gives the correct low 2*XLEN product bits for every op.
    assign ma      = {sa, io.in_a};
    assign mb      = {sb, io.in_b};
    assign prod    = {{(XLEN-1){ma[XLEN]}}, ma} * {{(XLEN-1){mb[XLEN]}}, mb};
    assign mul_res = io.in_op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign mag_a  = sa ? -io.in_a : io.in_a;
    assign mag_b  = sb ? -io.in_b : io.in_b;
    assign b_zero = io.in_b == '0;
    assign ovf    = is_signed_b(io.in_op) && io.in_a == {1'b1, {(XLEN-1){1'b0}}} && &io.in_b;
    // in_op[1] distinguishes REM/REMU from DIV/DIVU.
    assign spec_res = io.in_op[1] ? (b_zero ? io.in_a : '0) : (b_zero ? '1 : io.in_a);

    muldiv_divider #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start),
        .step_i     (step),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .done_o     (div_done),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        tag_d     = tag_q;
        rem_op_d  = rem_op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        start     = 1'b0;
        step      = 1'b0;
        if (io.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (io.in_valid) begin
                    tag_d = io.in_tag;
                    if (!is_div(io.in_op)) begin
                        state_d = S_DONE;
                        res_d   = mul_res;
                    end else if (b_zero || ovf) begin
                        state_d = S_DONE;
                        res_d   = spec_res;
                    end else begin
                        state_d   = S_DIV;
                        start     = 1'b1;
                        rem_op_d  = io.in_op[1];
                        neg_quo_d = sa ^ sb;
                        neg_rem_d = sa;
                    end
                end
                S_DIV: begin
                    step    = 1'b1;
                    state_d = div_done ? S_FIX : S_DIV;
                end
                S_FIX: begin
                    res_d   = rem_op_q ? (neg_rem_q ? -rem : rem) : (neg_quo_q ? -quot : quot);
                    state_d = S_DONE;
                end
                S_DONE: state_d = io.out_ready ? S_IDLE : S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            res_q     <= '0;
            tag_q     <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            tag_q     <= tag_d;
            rem_op_q  <= rem_op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign io.in_ready   = state_q == S_IDLE;
    assign io.out_valid  = state_q == S_DONE;
    assign io.busy       = state_q != S_IDLE;
    assign io.out_result = res_q;
    assign io.out_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_if #(.XLEN(32), .TAG_W(5)) bus();
    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .reset_n(reset_n), .io(bus));

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_op    = 3'($urandom);
        bus.in_tag   = 5'($urandom);
    endtask

    // lat counts edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.out_result); end
        n_cmp++; if (bus.out_tag !== 5'h0) begin n_bad++; $display("FAIL reset_tag: got %h want 0", bus.out_tag); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mul;
        logic [2:0]  ops [3] = '{OP_MULH, OP_MULHSU, OP_MULHU};
        logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int lat;
        bit bo;
        issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
        wait_valid(lat, bo);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL mul_latency: got %0d want 0", lat); end
        n_cmp++; if (bus.out_result !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result: got %h want ffffffeb", bus.out_result); end
        n_cmp++; if (bus.out_tag !== 5'd5) begin n_bad++; $display("FAIL mul_tag: got %0d want 5", bus.out_tag); end
        consume();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mul_in_ready_after: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 10));
            wait_valid(lat, bo);
            n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL mulh%0d_latency: got %0d want 0", i, lat); end
            n_cmp++; if (bus.out_result !== exp[i]) begin n_bad++; $display("FAIL mulh%0d_result: got %h want %h", i, bus.out_result, exp[i]); end
            consume();
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat;
        bit bo;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 20));
            wait_valid(lat, bo);
            n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div%0d_latency: got %0d want 33", i, lat); end
            n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL div%0d_busy: got %b want 1", i, bo); end
            n_cmp++; if (bus.out_result !== exp[i]) begin n_bad++; $display("FAIL div%0d_result: got %h want %h", i, bus.out_result, exp[i]); end
            n_cmp++; if (bus.out_tag !== 5'(i + 20)) begin n_bad++; $display("FAIL div%0d_tag: got %0d want %0d", i, bus.out_tag, i + 20); end
            consume();
        end
    endtask

    task automatic test_special;
        logic [2:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'd0};
        int lat;
        bit bo;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i));
            wait_valid(lat, bo);
            n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL spec%0d_latency: got %0d want 0", i, lat); end
            n_cmp++; if (bus.out_result !== exp[i]) begin n_bad++; $display("FAIL spec%0d_result: got %h want %h", i, bus.out_result, exp[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bit bo;
        int unstable = 0;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
        wait_valid(lat, bo);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd14 || bus.out_tag !== 5'd9 || bus.in_ready !== 1'b0) unstable++;
        end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
        n_cmp++; if (bus.out_result !== 32'd14) begin n_bad++; $display("FAIL bp_result: got %h want 0000000e", bus.out_result); end
        consume();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush;
        int lat;
        bit bo;
        bit seen = 1'b0;
        issue(OP_DIV, 32'd1000, 32'd3, 5'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_MUL;
        bus.in_a     = 32'd1;
        bus.in_b     = 32'd1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_result: got %b want 0", seen); end
        issue(OP_MUL, 32'd3, 32'd4, 5'd1);
        wait_valid(lat, bo);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL post_flush_latency: got %0d want 0", lat); end
        n_cmp++; if (bus.out_result !== 32'd12) begin n_bad++; $display("FAIL post_flush_result: got %h want 0000000c", bus.out_result); end
        consume();
    endtask

    task automatic test_reset_mid_div;
        int lat;
        bit bo;
        issue(OP_DIV, 32'd1000, 32'd3, 5'd2);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        issue(OP_DIV, 32'd20, 32'hFFFFFFFC, 5'd4);
        wait_valid(lat, bo);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL arst_div_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.out_result !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL arst_div_result: got %h want fffffffb", bus.out_result); end
        n_cmp++; if (bus.out_tag !== 5'd4) begin n_bad++; $display("FAIL arst_div_tag: got %0d want 4", bus.out_tag); end
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
